// File: rtl/four_bit_less_than_pkg.sv
// Shared definitions for the 4-bit unsigned magnitude comparator.
package four_bit_less_than_pkg;

   localparam int CMP_WIDTH = 4;

   // Compare outcome for downstream decoders that prefer a single code.
   typedef enum logic [1:0] {
      LT = 2'd0,
      EQ = 2'd1,
      GT = 2'd2
   } cmp_e;

   function automatic cmp_e to_cmp(input logic lt, input logic eq);
      if (lt)
         return LT;
      else if (eq)
         return EQ;
      else
         return GT;
   endfunction

endpackage

// File: rtl/four_bit_less_than_bit_cell.sv
// One-bit slice of the MSB-first comparator chain; a decided "less than"
// from a higher bit passes straight through, otherwise this bit may decide it.
module less_than_bit_cell (
   input  logic a,
   input  logic b,
   input  logic lt_in,
   input  logic eq_in,
   output logic lt_out,
   output logic eq_out
);

   assign lt_out = lt_in | (eq_in & ~a & b);
   assign eq_out = eq_in & ~(a ^ b);

endmodule

// File: rtl/four_bit_less_than.sv
// Unsigned 4-bit comparator: counter vs leading-zero-detector count.
// Define FOUR_BIT_LESS_THAN_REG_OUT_EN to add the registered result_reg output.
module four_bit_less_than
   import four_bit_less_than_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [CMP_WIDTH-1:0] counter,
   input  logic [CMP_WIDTH-1:0] lzd_output,
   output logic                 result,
   output logic                 equal,
`ifdef FOUR_BIT_LESS_THAN_REG_OUT_EN
   output logic                 greater,
   output logic                 result_reg
`else
   output logic                 greater
`endif
);

   // Index CMP_WIDTH is the seed entering the MSB cell; index 0 is the final stage.
   logic [CMP_WIDTH:0] lt_chain;
   logic [CMP_WIDTH:0] eq_chain;

   assign lt_chain[CMP_WIDTH] = 1'b0;
   assign eq_chain[CMP_WIDTH] = 1'b1;

   for (genvar i = CMP_WIDTH - 1; i >= 0; i--) begin : g_cell
      less_than_bit_cell u_cell (
         .a      (counter[i]),
         .b      (lzd_output[i]),
         .lt_in  (lt_chain[i+1]),
         .eq_in  (eq_chain[i+1]),
         .lt_out (lt_chain[i]),
         .eq_out (eq_chain[i])
      );
   end

   assign result  = lt_chain[0];
   assign equal   = eq_chain[0];
   assign greater = ~(lt_chain[0] | eq_chain[0]);

`ifdef FOUR_BIT_LESS_THAN_REG_OUT_EN
   always_ff @(posedge clk) begin
      if (rst)
         result_reg <= 1'b0;
      else
         result_reg <= result;
   end
`else
   // Clock and reset only serve the optional register.
   logic unused_clk_rst;
   assign unused_clk_rst = ^{clk, rst};
`endif

endmodule

// File: tb/tb_four_bit_less_than.sv
// Self-checking bench for four_bit_less_than; exercises result_reg when
// FOUR_BIT_LESS_THAN_REG_OUT_EN is defined.
module tb_four_bit_less_than;

   logic       clk;
   logic       rst;
   logic [3:0] counter;
   logic [3:0] lzd_output;
   logic       result;
   logic       equal;
   logic       greater;
`ifdef FOUR_BIT_LESS_THAN_REG_OUT_EN
   logic       result_reg;
`endif

   int n_cmp;
   int n_err;

   four_bit_less_than dut (
      .clk        (clk),
      .rst        (rst),
      .counter    (counter),
      .lzd_output (lzd_output),
      .result     (result),
      .equal      (equal),
`ifdef FOUR_BIT_LESS_THAN_REG_OUT_EN
      .greater    (greater),
      .result_reg (result_reg)
`else
      .greater    (greater)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: counter=%0d lzd=%0d got=%0d expected=%0d",
                tag, counter, lzd_output, obs, exp);
      end
   endtask

   // Reference: plain unsigned integer comparison of the two operands.
   task automatic apply_and_check(input string tag, input int c, input int l);
      int ones;
      counter    = c[3:0];
      lzd_output = l[3:0];
      #1;
      check({tag, "_lt"}, {3'b0, result},  {3'b0, (c < l)});
      check({tag, "_eq"}, {3'b0, equal},   {3'b0, (c == l)});
      check({tag, "_gt"}, {3'b0, greater}, {3'b0, (c > l)});
      ones = int'(result) + int'(equal) + int'(greater);
      check({tag, "_onehot"}, ones[3:0], 4'd1);
   endtask

   initial begin
      n_cmp      = 0;
      n_err      = 0;
      rst        = 1'b1;
      counter    = 4'd0;
      lzd_output = 4'd0;

      // Directed cases
      apply_and_check("lt_0011_0111", 3, 7);
      apply_and_check("gt_msb_1000_0111", 8, 7);
      apply_and_check("eq_0101", 5, 5);
      apply_and_check("eq_1111", 15, 15);
      apply_and_check("lt_lsb_0000_0001", 0, 1);
      apply_and_check("gt_lsb_0001_0000", 1, 0);
      apply_and_check("eq_0000", 0, 0);

      // Exhaustive sweep
      for (int c = 0; c < 16; c++)
         for (int l = 0; l < 16; l++)
            apply_and_check("sweep", c, l);

      // Random pairs, toggling reset to confirm it has no combinational effect
      for (int k = 0; k < 64; k++) begin
         rst = 1'($urandom_range(0, 1));
         apply_and_check("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      end

`ifdef FOUR_BIT_LESS_THAN_REG_OUT_EN
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reg_reset", {3'b0, result_reg}, 4'd0);
      rst        = 1'b0;
      counter    = 4'd3;
      lzd_output = 4'd7;
      @(posedge clk); #1;
      check("reg_capture", {3'b0, result_reg}, 4'd1);
      counter    = 4'd9;
      lzd_output = 4'd2;
      @(posedge clk); #1;
      check("reg_capture_lo", {3'b0, result_reg}, 4'd0);
      counter    = 4'd3;
      lzd_output = 4'd7;
      @(posedge clk); #1;
      check("reg_capture_hi", {3'b0, result_reg}, 4'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("reg_midstream_reset", {3'b0, result_reg}, 4'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("reg_after_release", {3'b0, result_reg}, 4'd1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
